gen_rafagas: RTL and testbench

- Serial burst generator: on a start command, emits `reps` bursts of `len` consecutive 1s on a single-bit line.
- Each burst is followed by GAP cycles of 0.
- Stimulus/transmit side for the team's serial run-of-ones detectors. Its output drives a detector's `in` port directly, on the same clock.
- Moore-style output, one FSM plus two down-counters.

---
 rtl/gen_rafagas_pkg.sv | 22 ++
 rtl/contador_desc.sv | 31 +++
 rtl/gen_rafagas.sv | 151 +++++++++++++++
 tb/tb_gen_rafagas.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_rafagas_pkg.sv
// Shared types and default widths for the serial burst generator.
package gen_rafagas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UNOS,
    PAUSA,
    FIN
  } estado_t;

  localparam int LEN_W_DEF = 4;
  localparam int REP_W_DEF = 4;
  localparam int GAP_DEF   = 1;

  // Gap counter must hold GAP itself; never narrower than one bit.
  function automatic int ancho_gap(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/contador_desc.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module contador_desc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_uno,
  output logic         o_cero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_uno  = (r_cnt == W'(1));
  assign o_cero = (r_cnt == '0);

endmodule

// File: rtl/gen_rafagas.sv
// Serial burst generator: reps bursts of len ones, each followed by
// GAP zeros, then a one-cycle done pulse.
module gen_rafagas
  import gen_rafagas_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int GW = ancho_gap(GAP);
  localparam logic [GW-1:0] GAP_V = GW'(GAP);

  if (GAP < 1 || GAP > 255) begin : g_gap_invalido
    $error("gen_rafagas: GAP must be in 1..255");
  end

  estado_t          r_estado;
  estado_t          w_sig;
  logic [LEN_W-1:0] r_len;

  logic             w_acepta;
  logic             w_ld_bits;
  logic [LEN_W-1:0] w_val_bits;
  logic             w_dec_bits;
  logic             w_ld_rep;
  logic             w_dec_rep;
  logic             w_ld_gap;
  logic             w_dec_gap;

  logic             w_bits_uno;
  logic             w_bits_cero;
  logic             w_rep_uno;
  logic             w_rep_cero;
  logic             w_gap_uno;
  logic             w_gap_cero;
  logic [LEN_W-1:0] w_bits_cnt;
  logic [REP_W-1:0] w_rep_cnt;
  logic [GW-1:0]    w_gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= IDLE;
      r_len    <= '0;
    end else begin
      r_estado <= w_sig;
      if (w_acepta) begin
        r_len <= len;
      end
    end
  end

  always_comb begin
    w_sig      = r_estado;
    w_acepta   = 1'b0;
    w_ld_bits  = 1'b0;
    w_val_bits = len;
    w_dec_bits = 1'b0;
    w_ld_rep   = 1'b0;
    w_dec_rep  = 1'b0;
    w_ld_gap   = 1'b0;
    w_dec_gap  = 1'b0;
    unique case (r_estado)
      IDLE: begin
        if (start) begin
          if ((len != '0) && (reps != '0)) begin
            w_acepta  = 1'b1;
            w_ld_bits = 1'b1;
            w_ld_rep  = 1'b1;
            w_sig     = UNOS;
          end else begin
            w_sig = FIN;
          end
        end
      end
      UNOS: begin
        if (w_bits_uno || w_bits_cero) begin
          w_ld_gap = 1'b1;
          w_sig    = PAUSA;
        end else begin
          w_dec_bits = 1'b1;
        end
      end
      PAUSA: begin
        if (!(w_gap_uno || w_gap_cero)) begin
          w_dec_gap = 1'b1;
        end else if (w_rep_uno || w_rep_cero) begin
          w_sig = FIN;
        end else begin
          w_dec_rep  = 1'b1;
          w_ld_bits  = 1'b1;
          w_val_bits = r_len;
          w_sig      = UNOS;
        end
      end
      FIN: begin
        w_sig = IDLE;
      end
      default: begin
        w_sig = IDLE;
      end
    endcase
  end

  assign out  = (r_estado == UNOS);
  assign busy = (r_estado != IDLE);
  assign done = (r_estado == FIN);

  contador_desc #(.W(LEN_W)) u_bits (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ld_bits),
    .i_val  (w_val_bits),
    .i_dec  (w_dec_bits),
    .o_cnt  (w_bits_cnt),
    .o_uno  (w_bits_uno),
    .o_cero (w_bits_cero)
  );

  contador_desc #(.W(REP_W)) u_rep (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ld_rep),
    .i_val  (reps),
    .i_dec  (w_dec_rep),
    .o_cnt  (w_rep_cnt),
    .o_uno  (w_rep_uno),
    .o_cero (w_rep_cero)
  );

  contador_desc #(.W(GW)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ld_gap),
    .i_val  (GAP_V),
    .i_dec  (w_dec_gap),
    .o_cnt  (w_gap_cnt),
    .o_uno  (w_gap_uno),
    .o_cero (w_gap_cero)
  );

endmodule

// File: tb/tb_gen_rafagas.sv
// Directed bench: GAP=1 and GAP=3 instances checked cycle by cycle
// against per-instance queues of expected {out,busy,done}.
module tb_gen_rafagas;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic       start1, start3;
  logic [3:0] len1, len3;
  logic [3:0] reps1, reps3;
  logic       out1, busy1, done1;
  logic       out3, busy3, done3;

  logic [2:0] q1[$];
  logic [2:0] q3[$];

  int checks = 0;
  int errors = 0;
  int n_out, n_busy, n_done;
  string step;

  always #5 clk = ~clk;

  gen_rafagas #(.LEN_W(4), .REP_W(4), .GAP(1)) d1 (
    .clk   (clk),
    .rst   (rst1),
    .start (start1),
    .len   (len1),
    .reps  (reps1),
    .out   (out1),
    .busy  (busy1),
    .done  (done1)
  );

  gen_rafagas #(.LEN_W(4), .REP_W(4), .GAP(3)) d3 (
    .clk   (clk),
    .rst   (rst3),
    .start (start3),
    .len   (len3),
    .reps  (reps3),
    .out   (out3),
    .busy  (busy3),
    .done  (done3)
  );

  task automatic push_run(input bit sel3, input int l, input int r,
                          input int g);
    logic [2:0] v;
    if (l == 0 || r == 0) begin
      v = 3'b011;
      if (sel3) q3.push_back(v); else q1.push_back(v);
      return;
    end
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < l; j++) begin
        v = 3'b110;
        if (sel3) q3.push_back(v); else q1.push_back(v);
      end
      for (int j = 0; j < g; j++) begin
        v = 3'b010;
        if (sel3) q3.push_back(v); else q1.push_back(v);
      end
    end
    v = 3'b011;
    if (sel3) q3.push_back(v); else q1.push_back(v);
  endtask

  task automatic tick();
    logic [2:0] e1, e3;
    @(posedge clk);
    #1;
    e1 = 3'b000;
    e3 = 3'b000;
    if (q1.size() > 0) e1 = q1.pop_front();
    if (q3.size() > 0) e3 = q3.pop_front();
    checks++;
    assert ({out1, busy1, done1} === e1) else begin
      errors++;
      $error("FAIL %s gap1 {out,busy,done} observed=%b expected=%b",
             step, {out1, busy1, done1}, e1);
    end
    checks++;
    assert ({out3, busy3, done3} === e3) else begin
      errors++;
      $error("FAIL %s gap3 {out,busy,done} observed=%b expected=%b",
             step, {out3, busy3, done3}, e3);
    end
    if (out1)  n_out++;
    if (busy1) n_busy++;
    if (done1) n_done++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q1.size() > 0 || q3.size() > 0) && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    start1 = 1'b0; start3 = 1'b0;
    len1 = '0; reps1 = '0; len3 = '0; reps3 = '0;
    step = "reset";
    tick();
    tick();
    rst1 = 1'b0; rst3 = 1'b0;
    tick();

    step = "t1_len3_rep2";
    start1 = 1'b1; len1 = 4'd3; reps1 = 4'd2;
    push_run(1'b0, 3, 2, 1);
    n_busy = 0; n_done = 0; n_out = 0;
    tick();
    start1 = 1'b0;
    drain();
    checks++;
    assert (n_busy === 9) else begin
      errors++;
      $error("FAIL t1_busy_cycles observed=%0d expected=%0d", n_busy, 9);
    end
    tick();

    step = "t2_len0";
    start1 = 1'b1; len1 = 4'd0; reps1 = 4'd5;
    push_run(1'b0, 0, 5, 1);
    n_busy = 0; n_out = 0;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    checks++;
    assert (n_busy === 1 && n_out === 0) else begin
      errors++;
      $error("FAIL t2_busy_out observed=%0d/%0d expected=1/0",
             n_busy, n_out);
    end

    step = "t3_restart_ignored";
    start1 = 1'b1; len1 = 4'd3; reps1 = 4'd2;
    push_run(1'b0, 3, 2, 1);
    n_done = 0;
    tick();
    start1 = 1'b0;
    tick();
    start1 = 1'b1; len1 = 4'd7; reps1 = 4'd9;
    tick();
    tick();
    len1 = 4'd1; reps1 = 4'd1;
    tick();
    start1 = 1'b0;
    drain();
    tick();
    checks++;
    assert (n_done === 1) else begin
      errors++;
      $error("FAIL t3_done_pulses observed=%0d expected=%0d", n_done, 1);
    end

    step = "t4_reset_mid";
    start1 = 1'b1; len1 = 4'd3; reps1 = 4'd2;
    push_run(1'b0, 3, 2, 1);
    tick();
    start1 = 1'b0;
    tick();
    rst1 = 1'b1;
    q1.delete();
    q1.push_back(3'b000);
    tick();
    rst1 = 1'b0;
    tick();
    start1 = 1'b1; len1 = 4'd2; reps1 = 4'd1;
    push_run(1'b0, 2, 1, 1);
    tick();
    start1 = 1'b0;
    drain();
    tick();

    step = "t5_max";
    start1 = 1'b1; len1 = 4'd15; reps1 = 4'd15;
    push_run(1'b0, 15, 15, 1);
    n_busy = 0; n_out = 0; n_done = 0;
    tick();
    start1 = 1'b0;
    drain();
    tick();
    tick();
    checks++;
    assert (n_busy === 241) else begin
      errors++;
      $error("FAIL t5_busy observed=%0d expected=%0d", n_busy, 241);
    end
    checks++;
    assert (n_out === 225) else begin
      errors++;
      $error("FAIL t5_ones observed=%0d expected=%0d", n_out, 225);
    end
    checks++;
    assert (n_done === 1) else begin
      errors++;
      $error("FAIL t5_done observed=%0d expected=%0d", n_done, 1);
    end

    step = "t6_gap3";
    start3 = 1'b1; len3 = 4'd1; reps3 = 4'd3;
    push_run(1'b1, 1, 3, 3);
    tick();
    start3 = 1'b0;
    drain();
    start3 = 1'b1; len3 = 4'd2; reps3 = 4'd2;
    q3.push_back(3'b000);
    tick();
    step = "t6_back_to_back";
    push_run(1'b1, 2, 2, 3);
    tick();
    start3 = 1'b0;
    drain();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
